// File: rtl/input_cond_pkg.sv
// Shared types and timing defaults for the push-button move conditioner.
// Direction codes double as bit positions in the 4-bit direction vectors
// (bit 0 = up ... bit 3 = right), so the enum order is also the arbitration order.
package input_cond_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Last direction that produced a move; valid drops once that button is released.
  typedef struct packed {
    logic valid;
    dir_e dir;
  } last_dir_t;

  // Defaults for a 25 MHz clock.
  localparam int DEF_DEBOUNCE_LIMIT = 250000;
  localparam int DEF_MOVE_COOLDOWN  = 2500000;
  localparam int DEF_REPEAT_CYCLES  = 7500000;

  // Highest-priority direction among simultaneous press events (up wins, right loses).
  function automatic dir_e pick_dir(input logic [3:0] events);
    dir_e winner;
    if (events[0])      winner = DIR_UP;
    else if (events[1]) winner = DIR_DOWN;
    else if (events[2]) winner = DIR_LEFT;
    else                winner = DIR_RIGHT;
    return winner;
  endfunction

  // One-hot move vector for a direction, in the same bit order as the enum.
  function automatic logic [3:0] dir_onehot(input dir_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button channel: 2-FF synchroniser, counting debouncer and a
// registered one-cycle pulse on each debounced press (0 -> 1).
module button_debounce
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_State,
  output logic o_Press
);

  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic             prev_q,  prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Count cycles the synced input disagrees with the debounced state; flip only after a full run.
  always_comb begin
    sync1_d = i_Switch;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    prev_d  = state_q;
    press_d = state_q & ~prev_q;
  end

  // All channel state clears on reset, so a button held through reset re-debounces as a new press.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_State = state_q;
  assign o_Press = press_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Turns raw push buttons into clean single-cycle move and start commands for
// frogger_game: debounced press events are arbitrated (up > down > left > right),
// followed by a cooldown, and the last direction auto-repeats while held.
module move_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
  parameter int MOVE_COOLDOWN  = DEF_MOVE_COOLDOWN,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_Up,
  input  logic i_Switch_Down,
  input  logic i_Switch_Left,
  input  logic i_Switch_Right,
  input  logic i_Switch_Start,
  output logic o_Up_Mvt,
  output logic o_Down_Mvt,
  output logic o_Left_Mvt,
  output logic o_Right_Mvt,
  output logic o_Game_Start,
  output logic o_Any_Held
);

  localparam int CD_W = (MOVE_COOLDOWN > 1) ? $clog2(MOVE_COOLDOWN) : 1;
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MOVE_COOLDOWN - 1);
  localparam logic [RP_W-1:0] RP_MAX  = RP_W'(REPEAT_CYCLES - 1);

  logic [3:0] raw_dir;
  logic [3:0] dir_state;
  logic [3:0] dir_press;
  logic       start_press;
  logic       start_state_unused;

  logic [3:0]      move_q,     move_d;
  logic            start_q,    start_d;
  logic            held_q,     held_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic [RP_W-1:0] repeat_q,   repeat_d;
  last_dir_t       last_q,     last_d;
  dir_e            winner;

  assign raw_dir = {i_Switch_Right, i_Switch_Left, i_Switch_Down, i_Switch_Up};

  for (genvar g = 0; g < 4; g++) begin : g_dir
    button_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_dir_btn (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Switch(raw_dir[g]),
      .o_State (dir_state[g]),
      .o_Press (dir_press[g])
    );
  end

  button_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_start_btn (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch_Start),
    .o_State (start_state_unused),
    .o_Press (start_press)
  );

  // Arbitrate fresh presses, run the cooldown, and auto-repeat the held last direction.
  always_comb begin
    move_d     = '0;
    cooldown_d = cooldown_q;
    repeat_d   = repeat_q;
    last_d     = last_q;
    winner     = pick_dir(dir_press);
    start_d    = start_press;
    held_d     = |dir_state;

    if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end

    if (last_q.valid && !dir_state[last_q.dir]) begin
      last_d.valid = 1'b0;
      repeat_d     = '0;
    end else if (last_q.valid && repeat_q != RP_MAX) begin
      repeat_d = repeat_q + RP_W'(1);
    end

    if (cooldown_q == '0 && |dir_press) begin
      move_d     = dir_onehot(winner);
      cooldown_d = CD_LOAD;
      repeat_d   = '0;
      last_d     = '{valid: 1'b1, dir: winner};
    end else if (last_q.valid && dir_state[last_q.dir] && repeat_q == RP_MAX) begin
      move_d     = dir_onehot(last_q.dir);
      cooldown_d = CD_LOAD;
      repeat_d   = '0;
    end
  end

  // Register every output and discard any in-flight cooldown or repeat on reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      move_q     <= '0;
      start_q    <= 1'b0;
      held_q     <= 1'b0;
      cooldown_q <= '0;
      repeat_q   <= '0;
      last_q     <= '{valid: 1'b0, dir: DIR_UP};
    end else begin
      move_q     <= move_d;
      start_q    <= start_d;
      held_q     <= held_d;
      cooldown_q <= cooldown_d;
      repeat_q   <= repeat_d;
      last_q     <= last_d;
    end
  end

  assign o_Up_Mvt     = move_q[DIR_UP];
  assign o_Down_Mvt   = move_q[DIR_DOWN];
  assign o_Left_Mvt   = move_q[DIR_LEFT];
  assign o_Right_Mvt  = move_q[DIR_RIGHT];
  assign o_Game_Start = start_q;
  assign o_Any_Held   = held_q;

endmodule
